// File: rtl/tile_pair_ctrl.sv
// ============================================================================
// Module      : tile_pair_ctrl
// Description : Registered game sequencer for the 4x4 memory-tile board.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tile_pair_ctrl #(
    parameter int          REVEAL_CYCLES = 100_000_000,
    parameter logic [15:0] MIRROR_INIT   = 16'h8208,
    parameter int          MOVE_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              key_evt,
    input  logic [4:0]        key_code,
    input  logic              hint,
    input  logic [47:0]       answer_tbl,
    output logic [15:0]       flipped,
    output logic [15:0]       mirrored,
    output logic [15:0]       reveal,
    output logic              hint_active,
    output logic              pass,
    output logic [2:0]        state_o,
    output logic [MOVE_W-1:0] moves
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_SHOW   = 3'd1,
        S_IDLE   = 3'd2,
        S_ONE    = 3'd3,
        S_TWO    = 3'd4,
        S_HOLD   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    localparam int              c_TW         = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TIMER_LOAD = c_TW'(REVEAL_CYCLES - 1);

    state_t            r_state;
    logic [15:0]       r_flipped;
    logic [15:0]       r_mirrored;
    logic [15:0]       r_reveal;
    logic [MOVE_W-1:0] r_moves;
    logic [3:0]        r_sel1;
    logic [3:0]        r_sel2;
    logic              r_arm;
    logic [c_TW-1:0]   r_timer;

    logic              w_key_ok;
    logic              w_is_tile;
    logic              w_is_shift;
    logic              w_is_enter;
    logic [15:0]       w_tile_bit;
    logic              w_tile_free;
    logic [15:0]       w_sel1_bit;
    logic [15:0]       w_sel2_bit;
    logic [5:0]        w_ofs1;
    logic [5:0]        w_ofs2;
    logic              w_match;
    logic [15:0]       w_new_flipped;

    assign w_key_ok    = key_evt && !hint && (key_code < 5'd18);
    assign w_is_tile   = w_key_ok && !key_code[4];
    assign w_is_shift  = w_key_ok && (key_code == 5'd16);
    assign w_is_enter  = w_key_ok && (key_code == 5'd17);

    // Tile i lives at bit 15-i in every mask.
    assign w_tile_bit  = 16'h8000 >> key_code[3:0];
    assign w_tile_free = ~|(r_flipped & w_tile_bit);
    assign w_sel1_bit  = 16'h8000 >> r_sel1;
    assign w_sel2_bit  = 16'h8000 >> r_sel2;

    // 3*sel computed as sel + 2*sel to keep the select index narrow.
    assign w_ofs1 = {2'b00, r_sel1} + {1'b0, r_sel1, 1'b0};
    assign w_ofs2 = {2'b00, r_sel2} + {1'b0, r_sel2, 1'b0};

    assign w_match = (answer_tbl[w_ofs1 +: 3] == answer_tbl[w_ofs2 +: 3])
                  && ~|(r_mirrored & (w_sel1_bit | w_sel2_bit));
    assign w_new_flipped = r_flipped | w_sel1_bit | w_sel2_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_flipped  <= 16'h0000;
            r_mirrored <= MIRROR_INIT;
            r_reveal   <= 16'h0000;
            r_moves    <= '0;
            r_sel1     <= 4'd0;
            r_sel2     <= 4'd0;
            r_arm      <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_flipped  <= 16'h0000;
                    r_mirrored <= MIRROR_INIT;
                    r_moves    <= '0;
                    if (start) begin
                        r_state  <= S_SHOW;
                        r_reveal <= 16'hFFFF;
                    end
                end
                S_SHOW: begin
                    if (start) begin
                        r_state  <= S_IDLE;
                        r_reveal <= 16'h0000;
                    end
                end
                S_IDLE: begin
                    if (w_is_tile && w_tile_free) begin
                        if (r_arm) begin
                            r_mirrored <= r_mirrored ^ w_tile_bit;
                            r_arm      <= 1'b0;
                        end else begin
                            r_sel1   <= key_code[3:0];
                            r_reveal <= r_reveal | w_tile_bit;
                            r_state  <= S_ONE;
                        end
                    end else if (w_is_shift) begin
                        r_arm <= ~r_arm;
                    end
                end
                S_ONE: begin
                    if (w_is_tile) begin
                        if (key_code[3:0] == r_sel1) begin
                            r_reveal <= 16'h0000;
                            r_state  <= S_IDLE;
                        end else if (w_tile_free) begin
                            r_sel2   <= key_code[3:0];
                            r_reveal <= r_reveal | w_tile_bit;
                            r_state  <= S_TWO;
                        end
                    end else if (w_is_shift) begin
                        r_mirrored <= r_mirrored ^ w_sel1_bit;
                    end
                end
                S_TWO: begin
                    if (w_is_enter) begin
                        if (r_moves != '1) begin
                            r_moves <= r_moves + 1'b1;
                        end
                        if (w_match) begin
                            r_flipped <= w_new_flipped;
                            r_reveal  <= 16'h0000;
                            if (w_new_flipped == 16'hFFFF) begin
                                r_state    <= S_FINISH;
                                r_mirrored <= 16'h0000;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_timer <= c_TIMER_LOAD;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_timer == '0) begin
                        r_reveal <= 16'h0000;
                        r_state  <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_FINISH: begin
                    r_flipped  <= 16'hFFFF;
                    r_mirrored <= 16'h0000;
                    r_reveal   <= 16'h0000;
                    if (start) begin
                        r_state    <= S_INIT;
                        r_flipped  <= 16'h0000;
                        r_mirrored <= MIRROR_INIT;
                        r_moves    <= '0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign flipped     = r_flipped;
    assign mirrored    = r_mirrored;
    assign reveal      = r_reveal;
    assign moves       = r_moves;
    assign state_o     = r_state;
    assign pass        = (r_state == S_FINISH);
    assign hint_active = hint && ((r_state == S_IDLE) || (r_state == S_ONE)
                               || (r_state == S_TWO)  || (r_state == S_HOLD));

endmodule

`default_nettype wire
